// File: rtl/regfile_ctrl_pkg.sv
// Shared types and default sizes for the register-file write arbiter.
// Optional build macro: REGFILE_R0_DROP_EN (suppresses the write strobe for register 0).
package regfile_ctrl_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_ADDR_W  = 5;
   localparam int DEF_DATA_W  = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2
   } state_t;

   // Width of a requester index; never zero so a 1-bit port always exists.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first valid requester after the last winner
// and advances its pointer only when the caller reports a completed transfer.
module rr_arbiter
   import regfile_ctrl_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   localparam int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any
);

   logic [IDX_W-1:0] ptr_q;
   logic             found;
   int               cand;

   assign any = |req;

   // NOTE: every variable assigned in this block gets a default first, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = (int'(ptr_q) + off) % NUM_REQ;
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = IDX_W'(cand);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its inputs from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= IDX_W'(NUM_REQ - 1);
      end else if (advance) begin
         ptr_q <= grant_idx;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Multi-requester register-file write port: round-robin accept, one SETUP cycle
// with address/data stable, then a one-cycle Write strobe. Macro: REGFILE_R0_DROP_EN.
module regfile_write_arbiter
   import regfile_ctrl_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   parameter  int ADDR_W  = DEF_ADDR_W,
   parameter  int DATA_W  = DEF_DATA_W,
   localparam int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      Write,
   output logic [ADDR_W-1:0]         Write_Register,
   output logic [DATA_W-1:0]         Register_Data,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      busy
);

   state_t              state_q;
   state_t              state_d;
   logic [NUM_REQ-1:0]  arb_grant;
   logic [IDX_W-1:0]    arb_idx;
   logic                arb_any;
   logic                grant_en;
   logic                transfer;
   logic                r0_drop;
   logic                write_d;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;

   // SETUP is the only state that refuses new requests.
   assign grant_en  = (state_q != ST_SETUP);
   assign req_ready = grant_en ? arb_grant : '0;
   assign transfer  = grant_en && arb_any;
   assign busy      = (state_q != ST_IDLE);

`ifdef REGFILE_R0_DROP_EN
   assign r0_drop = (Write_Register == '0);
`else
   assign r0_drop = 1'b0;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .clk       (clk),
      .reset     (reset),
      .req       (req_valid),
      .advance   (transfer),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any       (arb_any)
   );

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      write_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_any) state_d = ST_SETUP;
         end
         ST_SETUP: begin
            state_d = ST_STROBE;
            write_d = !r0_drop;
         end
         ST_STROBE: begin
            state_d = arb_any ? ST_SETUP : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: the address/data holding registers are reset as well, so the
   // register-file port shows defined zeros right after reset, not stale data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         Write          <= 1'b0;
         Write_Register <= '0;
         Register_Data  <= '0;
         grant_id       <= '0;
      end else begin
         state_q <= state_d;
         Write   <= write_d;
         if (transfer) begin
            Write_Register <= sel_addr;
            Register_Data  <= sel_data;
            grant_id       <= arb_idx;
         end
      end
   end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.
REQ-003 SHALL have parameter DATA_W, default 32, register data width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have req_valid  input  NUM_REQ  per-requester write request.
REQ-007 SHALL have req_addr  input  NUM_REQ*ADDR_W  per-requester target register; slice i is requester i.
REQ-008 SHALL have req_data  input  NUM_REQ*DATA_W  per-requester write data; slice i is requester i.
REQ-009 SHALL have req_ready  output  NUM_REQ  one-hot accept; a transfer occurs when valid and ready are both high at a clk edge.
REQ-010 SHALL have Write  output  1  register-file write strobe.
REQ-011 SHALL have Write_Register  output  ADDR_W  register-file write address.
REQ-012 SHALL have Register_Data  output  DATA_W  register-file write data.
REQ-013 SHALL have grant_id  output  clog2(NUM_REQ)  index of the requester currently being written.
REQ-014 SHALL have busy  output  1  high in SETUP and STROBE.

Function
REQ-015 SHALL implement an FSM with states IDLE, SETUP and STROBE.
REQ-016 IDLE: if any req_valid is high, SHALL assert req_ready for the round-robin winner only, then go to SETUP; otherwise stay in IDLE.
REQ-017 SETUP: Write_Register, Register_Data and grant_id SHALL hold the latched request, Write SHALL be 0, and the next state SHALL be STROBE unconditionally.
REQ-018 STROBE: Write SHALL be 1 for exactly one cycle with address and data unchanged from SETUP.
REQ-019 STROBE: if any req_valid is high, SHALL assert ready to the new winner and go to SETUP; otherwise go to IDLE.
REQ-020 Write, Write_Register, Register_Data and grant_id SHALL be registered outputs; req_ready SHALL be combinational from state, req_valid and pointer.
REQ-021 Latency: a transfer at edge N SHALL present address/data from N+1 and raise Write from N+2 to N+3.
REQ-022 Throughput: SHALL sustain one write per 2 cycles under continuous requests.
REQ-023 Arbitration: priority SHALL start at last_winner+1 mod NUM_REQ; the pointer SHALL update only on a transfer.
REQ-024 req_ready SHALL be 0 for all requesters in SETUP.
REQ-025 A requester dropping req_valid without a transfer SHALL cause no write.
REQ-026 Address and data SHALL be latched at transfer; later changes on req_addr/req_data SHALL NOT affect an in-flight write.

Reset
REQ-027 On reset: state IDLE, Write 0, Write_Register 0, Register_Data 0, grant_id 0, busy 0, pointer NUM_REQ-1 (requester 0 wins first).
REQ-028 Reset asserted mid-write SHALL clear Write immediately; the in-flight write SHALL be discarded and not retried.

Configuration
REQ-029 With REGFILE_R0_DROP_EN defined, a transfer to address 0 SHALL be accepted and sequenced normally, but Write SHALL stay 0 in STROBE.
REQ-030 Without REGFILE_R0_DROP_EN, address 0 SHALL be written like any other register.

Structure
REQ-031 Package regfile_ctrl_pkg SHALL hold the FSM state typedef and the default ADDR_W/DATA_W/NUM_REQ constants.
REQ-032 Round-robin selection plus pointer SHALL be a sub-module rr_arbiter, instantiated once.

Verification
REQ-033 Single request: req0 valid, addr 3, data 0xABCB_D695 -> ready0 at N; Write_Register 3 from N+1; Write high N+2..N+3.
REQ-034 All four valid continuously -> grants 0,1,2,3,0 in order; one Write pulse per 2 cycles, no gaps.
REQ-035 Req1 and req2 valid, last winner 1 -> req2 granted first, req1 next.
REQ-036 Write to address 0 with data 0x39CE_7F9E -> Write pulses without REGFILE_R0_DROP_EN; Write stays 0 with it, ready still given.
REQ-037 Reset asserted during STROBE -> Write falls asynchronously; all outputs at reset values; next grant goes to requester 0.
REQ-038 req_data changed after transfer -> Register_Data keeps the latched value through STROBE.
